obi_bus_arbiter: RTL and testbench

Single-outstanding OBI arbiter and transaction sequencer between the CV32E40X instruction and data ports and the shared SoC bus. It arbitrates the two requesters with data priority and a bounded instruction-starvation guarantee. It decodes each access as internal (dual-port RAM, fixed one-cycle read latency) or external (OBI-WB bridge, variable gnt/rvalid latency) and generates grant and rvalid for both paths. It sits between the core and the RAM/bridge datapath in the SoC top.

---
 rtl/obi_bus_arbiter.sv | 177 +++++++++++++++++
 tb/tb_obi_bus_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_bus_arbiter.sv
// rtl/obi_bus_arbiter.sv - single-outstanding OBI arbiter/sequencer for CV32E40X instr and data ports
// Optional external-access timeout and error response: define OBI_ARB_TIMEOUT_EN.
module obi_bus_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned EXT_SEL_BIT    = 22,
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  instr_req_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  output logic [31:0]           instr_rdata_o,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [31:0]           data_wdata_i,
  output logic [31:0]           data_rdata_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic                  bus_we_o,
  output logic [3:0]            bus_be_o,
  output logic [31:0]           bus_wdata_o,
  output logic                  int_req_o,
  input  logic [31:0]           int_rdata_i,
  output logic                  ext_req_o,
  input  logic                  ext_gnt_i,
  input  logic                  ext_rvalid_i,
  input  logic [31:0]           ext_rdata_i,
  output logic                  bus_err_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o
);

  typedef enum logic [2:0] {IDLE, INT_RSP, EXT_GNT, EXT_RSP, ERR_RSP} state_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

  state_e     state_q, state_d;
  logic       owner_instr_q, owner_instr_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;

  logic        sel_instr, mux_instr, any_req, tmo;
  logic        gnt, rvalid;
  logic [31:0] rdata;

  always_comb begin
    any_req   = instr_req_i | data_req_i;
    sel_instr = instr_req_i & (~data_req_i | (starve_cnt_q == STARVE_LIM));
    mux_instr = (state_q == IDLE) ? sel_instr : owner_instr_q;
  end

  assign bus_addr_o  = mux_instr ? instr_addr_i : data_addr_i;
  assign bus_we_o    = mux_instr ? 1'b0 : data_we_i;
  assign bus_be_o    = mux_instr ? 4'hF : data_be_i;
  assign bus_wdata_o = mux_instr ? 32'h0 : data_wdata_i;

`ifdef OBI_ARB_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0]         tmo_cnt_q, tmo_cnt_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

  assign tmo = ((state_q == EXT_GNT) || (state_q == EXT_RSP)) &&
               (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign bus_err_o  = (state_q == ERR_RSP);
  assign err_addr_o = err_addr_q;
`else
  assign tmo        = 1'b0;
  assign bus_err_o  = 1'b0;
  assign err_addr_o = '0;
`endif

  always_comb begin
    state_d       = state_q;
    owner_instr_d = owner_instr_q;
    starve_cnt_d  = starve_cnt_q;
    gnt           = 1'b0;
    rvalid        = 1'b0;
    rdata         = 32'h0;
    int_req_o     = 1'b0;
    ext_req_o     = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req && rst_ni) begin
          owner_instr_d = sel_instr;
          if (sel_instr) begin
            starve_cnt_d = 4'h0;
          end else if (instr_req_i && (starve_cnt_q != STARVE_LIM)) begin
            starve_cnt_d = starve_cnt_q + 4'h1;
          end
          // Internal RAM grants immediately; external waits for the bridge.
          if (!bus_addr_o[EXT_SEL_BIT]) begin
            gnt       = 1'b1;
            int_req_o = 1'b1;
            state_d   = INT_RSP;
          end else begin
            state_d = EXT_GNT;
          end
        end
      end
      INT_RSP: begin
        rvalid  = 1'b1;
        rdata   = int_rdata_i;
        state_d = IDLE;
      end
      EXT_GNT: begin
        if (tmo) begin
          gnt     = 1'b1;
          state_d = ERR_RSP;
        end else begin
          ext_req_o = 1'b1;
          gnt       = ext_gnt_i;
          if (ext_gnt_i) state_d = EXT_RSP;
        end
      end
      EXT_RSP: begin
        if (tmo) begin
          state_d = ERR_RSP;
        end else begin
          rvalid = ext_rvalid_i;
          rdata  = ext_rvalid_i ? ext_rdata_i : 32'h0;
          if (ext_rvalid_i) state_d = IDLE;
        end
      end
`ifdef OBI_ARB_TIMEOUT_EN
      ERR_RSP: begin
        rvalid  = 1'b1;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

`ifdef OBI_ARB_TIMEOUT_EN
  always_comb begin
    tmo_cnt_d = '0;
    if ((state_d == state_q) && ((state_q == EXT_GNT) || (state_q == EXT_RSP))) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
    err_addr_d = err_addr_q;
    if ((state_d == ERR_RSP) && (state_q != ERR_RSP)) err_addr_d = bus_addr_o;
  end
`endif

  assign instr_gnt_o    = gnt & mux_instr;
  assign data_gnt_o     = gnt & ~mux_instr;
  assign instr_rvalid_o = rvalid & mux_instr;
  assign data_rvalid_o  = rvalid & ~mux_instr;
  assign instr_rdata_o  = instr_rvalid_o ? rdata : 32'h0;
  assign data_rdata_o   = data_rvalid_o ? rdata : 32'h0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      owner_instr_q <= 1'b0;
      starve_cnt_q  <= 4'h0;
`ifdef OBI_ARB_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      err_addr_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      owner_instr_q <= owner_instr_d;
      starve_cnt_q  <= starve_cnt_d;
`ifdef OBI_ARB_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
      err_addr_q    <= err_addr_d;
`endif
    end
  end

endmodule

// File: tb/tb_obi_bus_arbiter.sv
// tb/tb_obi_bus_arbiter.sv - directed vector bench for obi_bus_arbiter
module tb_obi_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        instr_req_i, instr_gnt_o, instr_rvalid_o;
  logic [31:0] instr_addr_i, instr_rdata_o;
  logic        data_req_i, data_gnt_o, data_rvalid_o, data_we_i;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic [3:0]  data_be_i, bus_be_o;
  logic [31:0] bus_addr_o, bus_wdata_o, int_rdata_i, ext_rdata_i, err_addr_o;
  logic        bus_we_o, int_req_o, ext_req_o, ext_gnt_i, ext_rvalid_i, bus_err_o;

  int checks = 0;
  int errors = 0;

  obi_bus_arbiter #(
    .ADDR_WIDTH(32), .EXT_SEL_BIT(22), .STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
    .instr_addr_i(instr_addr_i), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_addr_i(data_addr_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o),
    .bus_addr_o(bus_addr_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .int_req_o(int_req_o), .int_rdata_i(int_rdata_i),
    .ext_req_o(ext_req_o), .ext_gnt_i(ext_gnt_i), .ext_rvalid_i(ext_rvalid_i),
    .ext_rdata_i(ext_rdata_i), .bus_err_o(bus_err_o), .err_addr_o(err_addr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic [31:0] daddr;
    logic        dwe;
    logic [3:0]  dbe;
    logic [31:0] dwdata;
    logic [31:0] irdata;
    logic        e_igrant;
    logic        e_dgrant;
    logic [31:0] e_addr;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_irdata;
    logic [31:0] e_drdata;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    instr_req_i = 0; instr_addr_i = 0;
    data_req_i = 0; data_addr_i = 0; data_we_i = 0; data_be_i = 0; data_wdata_i = 0;
    int_rdata_i = 0; ext_gnt_i = 0; ext_rvalid_i = 0; ext_rdata_i = 0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst_ni = 0;
    step();
    step();
    rst_ni = 1;
  endtask

  // The bridge model must never present gnt and rvalid together.
  always @(negedge clk) begin
    if (rst_ni === 1'b1 && ext_gnt_i && ext_rvalid_i) begin
      errors++;
      $display("FAIL bridge_gnt_rvalid_same_cycle: got 1 expected 0");
    end
  end

  task automatic run_vec(input int i, input vec_t v);
    string p;
    p = $sformatf("vec%0d", i);
    instr_req_i = v.ireq; instr_addr_i = v.iaddr;
    data_req_i = v.dreq; data_addr_i = v.daddr; data_we_i = v.dwe;
    data_be_i = v.dbe; data_wdata_i = v.dwdata; int_rdata_i = v.irdata;
    @(negedge clk);
    chk({p, "_instr_gnt"}, instr_gnt_o, v.e_igrant);
    chk({p, "_data_gnt"}, data_gnt_o, v.e_dgrant);
    chk({p, "_int_req"}, int_req_o, 1);
    chk({p, "_ext_req"}, ext_req_o, 0);
    chk({p, "_bus_addr"}, bus_addr_o, v.e_addr);
    chk({p, "_bus_we"}, bus_we_o, v.e_we);
    chk({p, "_bus_be"}, bus_be_o, v.e_be);
    chk({p, "_bus_wdata"}, bus_wdata_o, v.e_wdata);
    step();
    instr_req_i = 0; data_req_i = 0;
    @(negedge clk);
    chk({p, "_instr_rvalid"}, instr_rvalid_o, v.e_igrant);
    chk({p, "_data_rvalid"}, data_rvalid_o, v.e_dgrant);
    chk({p, "_instr_rdata"}, instr_rdata_o, v.e_irdata);
    chk({p, "_data_rdata"}, data_rdata_o, v.e_drdata);
    chk({p, "_gnt_in_rsp"}, {30'b0, instr_gnt_o, data_gnt_o}, 0);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int run;
    int ext_cnt;
    logic exp_i;

    vecs[0] = '{0, 32'h0, 1, 32'h10, 0, 4'hF, 32'h0, 32'hA5A5_5A5A,
                0, 1, 32'h10, 0, 4'hF, 32'h0, 32'h0, 32'hA5A5_5A5A};
    vecs[1] = '{1, 32'h0008_0000, 0, 32'h44, 1, 4'h3, 32'hFFFF, 32'h1111_2222,
                1, 0, 32'h0008_0000, 0, 4'hF, 32'h0, 32'h1111_2222, 32'h0};
    vecs[2] = '{0, 32'h0, 1, 32'h20, 1, 4'h3, 32'hDEAD_BEEF, 32'h55,
                0, 1, 32'h20, 1, 4'h3, 32'hDEAD_BEEF, 32'h0, 32'h55};
    vecs[3] = '{1, 32'h200, 1, 32'h300, 0, 4'hF, 32'h0, 32'h77,
                0, 1, 32'h300, 0, 4'hF, 32'h0, 32'h0, 32'h77};
    vecs[4] = '{1, 32'h003F_FFFC, 0, 32'h0, 0, 4'h0, 32'h0, 32'h9,
                1, 0, 32'h003F_FFFC, 0, 4'hF, 32'h0, 32'h9, 32'h0};

    do_reset();
    data_addr_i = 32'h1234; data_be_i = 4'h5; data_wdata_i = 32'hCAFE;
    @(negedge clk);
    chk("rst_gnt", {30'b0, instr_gnt_o, data_gnt_o}, 0);
    chk("rst_rvalid", {30'b0, instr_rvalid_o, data_rvalid_o}, 0);
    chk("rst_reqs", {30'b0, int_req_o, ext_req_o}, 0);
    chk("rst_bus_err", bus_err_o, 0);
    chk("rst_err_addr", err_addr_o, 0);
    chk("rst_bus_addr", bus_addr_o, 32'h1234);
    chk("rst_bus_be", bus_be_o, 4'h5);
    chk("rst_bus_wdata", bus_wdata_o, 32'hCAFE);
    step();

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // Both requesters held high: D,D,D,D,I repeating.
    do_reset();
    instr_req_i = 1; instr_addr_i = 32'h100;
    data_req_i = 1; data_addr_i = 32'h200; int_rdata_i = 32'h3;
    run = 0;
    for (int k = 0; k < 10; k++) begin
      exp_i = ((k % 5) == 4);
      @(negedge clk);
      chk($sformatf("starve_igrant%0d", k), instr_gnt_o, exp_i);
      chk($sformatf("starve_dgrant%0d", k), data_gnt_o, !exp_i);
      if (data_gnt_o) run++;
      if (instr_gnt_o) begin
        chk($sformatf("starve_wait%0d", k), run, 4);
        run = 0;
      end
      @(negedge clk);
      chk($sformatf("starve_irvalid%0d", k), instr_rvalid_o, exp_i);
    end
    step();
    idle_inputs();
    step();

    // External data write: bridge gnt in cycle 3, rvalid in cycle 5.
    ext_cnt = 0;
    for (int c = 0; c < 7; c++) begin
      if (c == 0) begin
        data_req_i = 1; data_addr_i = 32'h0040_0000; data_we_i = 1;
        data_be_i = 4'hF; data_wdata_i = 32'h0BAD_F00D;
      end
      if (c == 4) data_req_i = 0;
      ext_gnt_i = (c == 3); ext_rvalid_i = (c == 5); ext_rdata_i = 32'hFEED_0001;
      @(negedge clk);
      if (ext_req_o) ext_cnt++;
      chk($sformatf("extw_ext_req_c%0d", c), ext_req_o, (c >= 1 && c <= 3));
      chk($sformatf("extw_dgnt_c%0d", c), data_gnt_o, (c == 3));
      chk($sformatf("extw_drvalid_c%0d", c), data_rvalid_o, (c == 5));
      chk($sformatf("extw_drdata_c%0d", c), data_rdata_o, (c == 5) ? 32'hFEED_0001 : 32'h0);
      chk($sformatf("extw_int_req_c%0d", c), int_req_o, 0);
      if (c == 2) begin
        chk("extw_bus_we", bus_we_o, 1);
        chk("extw_bus_addr", bus_addr_o, 32'h0040_0000);
      end
      step();
    end
    chk("extw_ext_req_cycles", ext_cnt, 3);
    idle_inputs();

    // External instruction fetch returning 0x1234_5678.
    for (int c = 0; c < 5; c++) begin
      if (c == 0) begin instr_req_i = 1; instr_addr_i = 32'h0048_0000; end
      if (c == 2) instr_req_i = 0;
      ext_gnt_i = (c == 1); ext_rvalid_i = (c == 3); ext_rdata_i = 32'h1234_5678;
      @(negedge clk);
      chk($sformatf("exti_igrant_c%0d", c), instr_gnt_o, (c == 1));
      chk($sformatf("exti_irvalid_c%0d", c), instr_rvalid_o, (c == 3));
      chk($sformatf("exti_irdata_c%0d", c), instr_rdata_o, (c == 3) ? 32'h1234_5678 : 32'h0);
      chk($sformatf("exti_drvalid_c%0d", c), data_rvalid_o, 0);
      if (c == 1) chk("exti_bus_we", bus_we_o, 0);
      step();
    end
    idle_inputs();

    // Reset while waiting for the bridge grant.
    for (int c = 0; c < 6; c++) begin
      if (c == 0) begin data_req_i = 1; data_addr_i = 32'h0040_0010; end
      if (c == 2) begin rst_ni = 0; data_req_i = 0; end
      if (c == 3) rst_ni = 1;
      ext_rvalid_i = (c == 4); ext_rdata_i = 32'hBAD;
      @(negedge clk);
      chk($sformatf("rstx_ext_req_c%0d", c), ext_req_o, (c == 1 || c == 2));
      chk($sformatf("rstx_rvalid_c%0d", c), {30'b0, instr_rvalid_o, data_rvalid_o}, 0);
      chk($sformatf("rstx_drdata_c%0d", c), data_rdata_o, 0);
      step();
    end
    idle_inputs();

`ifdef OBI_ARB_TIMEOUT_EN
    // Silent bridge: forced grant after 8 cycles, then error response.
    for (int c = 0; c < 12; c++) begin
      if (c == 0) begin data_req_i = 1; data_addr_i = 32'h0040_0100; end
      if (c == 9) data_req_i = 0;
      ext_gnt_i = (c == 10);
      @(negedge clk);
      chk($sformatf("tmo_ext_req_c%0d", c), ext_req_o, (c >= 1 && c <= 7));
      chk($sformatf("tmo_dgnt_c%0d", c), data_gnt_o, (c == 8));
      chk($sformatf("tmo_drvalid_c%0d", c), data_rvalid_o, (c == 9));
      chk($sformatf("tmo_drdata_c%0d", c), data_rdata_o, 0);
      chk($sformatf("tmo_bus_err_c%0d", c), bus_err_o, (c == 9));
      if (c == 9 || c == 11) chk($sformatf("tmo_err_addr_c%0d", c), err_addr_o, 32'h0040_0100);
      step();
    end
`else
    // Silent bridge: request is held indefinitely, no error reporting.
    for (int c = 0; c < 23; c++) begin
      if (c == 0) begin data_req_i = 1; data_addr_i = 32'h0040_0100; end
      if (c == 21) data_req_i = 0;
      ext_gnt_i = (c == 20); ext_rvalid_i = (c == 21); ext_rdata_i = 32'h600D;
      @(negedge clk);
      chk($sformatf("wait_ext_req_c%0d", c), ext_req_o, (c >= 1 && c <= 20));
      chk($sformatf("wait_dgnt_c%0d", c), data_gnt_o, (c == 20));
      chk($sformatf("wait_drvalid_c%0d", c), data_rvalid_o, (c == 21));
      chk($sformatf("wait_bus_err_c%0d", c), bus_err_o, 0);
      chk($sformatf("wait_err_addr_c%0d", c), err_addr_o, 0);
      step();
    end
`endif
    idle_inputs();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
